// File: rtl/stopwatch_mmss_counter_pkg.sv
// Shared types and constants for the MM:SS stopwatch: FSM state encoding and BCD digit limits.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam logic [3:0] DIGIT_MAX_9 = 4'd9;
  localparam logic [3:0] DIGIT_MAX_5 = 4'd5;

endpackage

// File: rtl/stopwatch_mmss_counter_bcd_digit.sv
// One BCD digit counting 0..MAX; carry is combinational so a whole chain resolves in one clock.
module bcd_digit
  import stopwatch_pkg::*;
#(
  parameter logic [3:0] MAX = DIGIT_MAX_9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] q,
  output logic       carry
);

  logic [3:0] q_q;
  logic [3:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = 4'd0;
    end else if (inc) begin
      q_d = (q_q == MAX) ? 4'd0 : q_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= 4'd0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q     = q_q;
  assign carry = inc && (q_q == MAX);

endmodule

// File: rtl/stopwatch_mmss_counter.sv
// MM:SS BCD stopwatch driven by a synchronised, edge-detected slow tick with start/pause/clear control.
// Optional macro STOPWATCH_HOLD_AT_MAX_EN: hold at 59:59 and pause instead of wrapping.
module stopwatch_mmss_counter
  import stopwatch_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_in,
  input  logic       start_stop,
  input  logic       clear,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       running,
  output logic       tick_pulse,
  output logic       wrap
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic   edge_q, edge_d;
  state_t state_q, state_d;
  logic   running_q, running_d;
  logic   tick_pulse_q, tick_pulse_d;
  logic   wrap_q, wrap_d;

  logic tick;
  logic count_en;
  logic hold;
  logic inc_so;
  logic carry_so, carry_st, carry_mo, carry_mt;

  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], tick_in};
    edge_d   = sync_q[SYNC_STAGES-1];
    tick     = sync_q[SYNC_STAGES-1] && !edge_q;
    // Counting uses the state before any same-cycle start_stop; clear wins over everything.
    count_en = (state_q == RUN) && tick && !clear;
`ifdef STOPWATCH_HOLD_AT_MAX_EN
    hold     = count_en && (min_tens == DIGIT_MAX_5) && (min_ones == DIGIT_MAX_9) &&
               (sec_tens == DIGIT_MAX_5) && (sec_ones == DIGIT_MAX_9);
`else
    hold     = 1'b0;
`endif
    inc_so   = count_en && !hold;
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else if (hold) begin
      state_d = PAUSE;
    end else if (start_stop) begin
      unique case (state_q)
        IDLE:    state_d = RUN;
        RUN:     state_d = PAUSE;
`ifdef STOPWATCH_HOLD_AT_MAX_EN
        // A stopwatch parked at 59:59 can only be left through clear.
        PAUSE:   state_d = ((min_tens == DIGIT_MAX_5) && (min_ones == DIGIT_MAX_9) &&
                            (sec_tens == DIGIT_MAX_5) && (sec_ones == DIGIT_MAX_9)) ? PAUSE : RUN;
`else
        PAUSE:   state_d = RUN;
`endif
        default: state_d = IDLE;
      endcase
    end
    running_d    = (state_d == RUN);
    tick_pulse_d = inc_so;
    wrap_d       = carry_mt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q       <= '0;
      edge_q       <= 1'b0;
      state_q      <= IDLE;
      running_q    <= 1'b0;
      tick_pulse_q <= 1'b0;
      wrap_q       <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      edge_q       <= edge_d;
      state_q      <= state_d;
      running_q    <= running_d;
      tick_pulse_q <= tick_pulse_d;
      wrap_q       <= wrap_d;
    end
  end

  bcd_digit #(.MAX(DIGIT_MAX_9)) u_sec_ones (
    .clk(clk), .rst(rst), .clr(clear), .inc(inc_so),   .q(sec_ones), .carry(carry_so)
  );
  bcd_digit #(.MAX(DIGIT_MAX_5)) u_sec_tens (
    .clk(clk), .rst(rst), .clr(clear), .inc(carry_so), .q(sec_tens), .carry(carry_st)
  );
  bcd_digit #(.MAX(DIGIT_MAX_9)) u_min_ones (
    .clk(clk), .rst(rst), .clr(clear), .inc(carry_st), .q(min_ones), .carry(carry_mo)
  );
  bcd_digit #(.MAX(DIGIT_MAX_5)) u_min_tens (
    .clk(clk), .rst(rst), .clr(clear), .inc(carry_mo), .q(min_tens), .carry(carry_mt)
  );

  assign running    = running_q;
  assign tick_pulse = tick_pulse_q;
  assign wrap       = wrap_q;

endmodule

// File: tb/tb_stopwatch_mmss_counter.sv
// Directed bench for the MM:SS stopwatch: expected snapshots are queued when stimulus is driven, popped and checked when output appears.
module tb_stopwatch_mmss_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick_in;
  logic       start_stop;
  logic       clear;
  logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
  logic       running, tick_pulse, wrap;

  typedef struct packed {
    logic [15:0] digits;
    logic        run;
    logic        pulse;
    logic        wrp;
  } snap_t;

  snap_t exp_q[$];
  int    tests_run = 0;
  int    fails     = 0;

  stopwatch_mmss_counter #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .tick_in(tick_in), .start_stop(start_stop), .clear(clear),
    .sec_ones(sec_ones), .sec_tens(sec_tens), .min_ones(min_ones), .min_tens(min_tens),
    .running(running), .tick_pulse(tick_pulse), .wrap(wrap)
  );

  always #5 clk = ~clk;

  function automatic snap_t cur();
    snap_t s;
    s.digits = {min_tens, min_ones, sec_tens, sec_ones};
    s.run    = running;
    s.pulse  = tick_pulse;
    s.wrp    = wrap;
    return s;
  endfunction

  function automatic snap_t mk(input logic [15:0] d, input logic r, input logic p, input logic w);
    snap_t s;
    s.digits = d;
    s.run    = r;
    s.pulse  = p;
    s.wrp    = w;
    return s;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_ss();
    start_stop = 1'b1;
    step();
    start_stop = 1'b0;
  endtask

  task automatic pulse_clr();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  // One clean tick_in rise; optional start_stop/clear land on the edge where the tick is counted.
  task automatic pulse_tick(input logic ss, input logic clr, output snap_t s);
    tick_in = 1'b1;
    step();
    step();
    tick_in    = 1'b0;
    start_stop = ss;
    clear      = clr;
    step();
    start_stop = 1'b0;
    clear      = 1'b0;
    s = cur();
    step();
  endtask

  task automatic run_ticks(input int n);
    snap_t s;
    for (int i = 0; i < n; i++) pulse_tick(1'b0, 1'b0, s);
  endtask

  task automatic check_snap(input string tag, input snap_t s);
    snap_t e;
    tests_run++;
    assert (exp_q.size() > 0) else begin
      fails++;
      $error("FAIL %s scoreboard empty observed=%h expected=entry", tag, s);
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests_run++;
      assert (s.digits === e.digits) else begin
        fails++;
        $error("FAIL %s digits observed=%h expected=%h", tag, s.digits, e.digits);
      end
      tests_run++;
      assert (s.run === e.run) else begin
        fails++;
        $error("FAIL %s running observed=%b expected=%b", tag, s.run, e.run);
      end
      tests_run++;
      assert (s.pulse === e.pulse) else begin
        fails++;
        $error("FAIL %s tick_pulse observed=%b expected=%b", tag, s.pulse, e.pulse);
      end
      tests_run++;
      assert (s.wrp === e.wrp) else begin
        fails++;
        $error("FAIL %s wrap observed=%b expected=%b", tag, s.wrp, e.wrp);
      end
    end
    $display("[TB] %s digits=%h running=%b tick_pulse=%b wrap=%b", tag, s.digits, s.run, s.pulse, s.wrp);
  endtask

  initial begin
    snap_t s;
    int    pulse_cnt;
    int    pulse_at;

    rst = 1'b1; tick_in = 1'b1; start_stop = 1'b0; clear = 1'b0;
    repeat (3) step();
    rst = 1'b0;

    // Reset release with tick_in already high must not produce a pulse.
    pulse_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (tick_pulse !== 1'b0) pulse_cnt++;
    end
    tests_run++;
    assert (pulse_cnt === 0) else begin
      fails++;
      $error("FAIL reset_no_tick pulses observed=%0d expected=0", pulse_cnt);
    end
    exp_q.push_back(mk(16'h0000, 1'b0, 1'b0, 1'b0));
    check_snap("reset_state", cur());

    tick_in = 1'b0;
    repeat (3) step();
    pulse_ss();

    // Single held rise: exactly one pulse, two clocks after capture.
    tick_in   = 1'b1;
    pulse_cnt = 0;
    pulse_at  = -1;
    for (int i = 1; i <= 50; i++) begin
      step();
      if (tick_pulse === 1'b1) begin
        pulse_cnt++;
        if (pulse_at < 0) pulse_at = i;
      end
    end
    tick_in = 1'b0;
    tests_run++;
    assert (pulse_cnt === 1) else begin
      fails++;
      $error("FAIL first_tick_count observed=%0d expected=1", pulse_cnt);
    end
    tests_run++;
    assert (pulse_at === 3) else begin
      fails++;
      $error("FAIL first_tick_latency observed=%0d expected=3", pulse_at);
    end
    step();
    exp_q.push_back(mk(16'h0001, 1'b1, 1'b0, 1'b0));
    check_snap("first_tick", cur());

    run_ticks(598);
    exp_q.push_back(mk(16'h0959, 1'b1, 1'b0, 1'b0));
    check_snap("preload_0959", cur());
    exp_q.push_back(mk(16'h1000, 1'b1, 1'b1, 1'b0));
    pulse_tick(1'b0, 1'b0, s);
    check_snap("carry_1000", s);

    pulse_clr();
    pulse_ss();
    run_ticks(3599);
    exp_q.push_back(mk(16'h5959, 1'b1, 1'b0, 1'b0));
    check_snap("preload_5959", cur());
`ifdef STOPWATCH_HOLD_AT_MAX_EN
    exp_q.push_back(mk(16'h5959, 1'b0, 1'b0, 1'b0));
    pulse_tick(1'b0, 1'b0, s);
    check_snap("hold_at_max", s);
    pulse_ss();
    step();
    exp_q.push_back(mk(16'h5959, 1'b0, 1'b0, 1'b0));
    check_snap("hold_ss_stays_pause", cur());
`else
    exp_q.push_back(mk(16'h0000, 1'b1, 1'b1, 1'b1));
    pulse_tick(1'b0, 1'b0, s);
    check_snap("wrap_edge", s);
    exp_q.push_back(mk(16'h0000, 1'b1, 1'b0, 1'b0));
    check_snap("wrap_one_clk", cur());
`endif

    pulse_clr();
    pulse_ss();
    run_ticks(5);
    exp_q.push_back(mk(16'h0005, 1'b1, 1'b0, 1'b0));
    check_snap("at_0005", cur());
    exp_q.push_back(mk(16'h0006, 1'b0, 1'b1, 1'b0));
    pulse_tick(1'b1, 1'b0, s);
    check_snap("ss_tick_in_run", s);
    exp_q.push_back(mk(16'h0006, 1'b1, 1'b0, 1'b0));
    pulse_tick(1'b1, 1'b0, s);
    check_snap("ss_tick_in_pause", s);

    pulse_clr();
    pulse_ss();
    run_ticks(754);
    exp_q.push_back(mk(16'h1234, 1'b1, 1'b0, 1'b0));
    check_snap("at_1234", cur());
    exp_q.push_back(mk(16'h0000, 1'b0, 1'b0, 1'b0));
    pulse_tick(1'b1, 1'b1, s);
    check_snap("clear_priority", s);

    // Asynchronous reset mid-count: outputs must drop before the next clock edge.
    pulse_ss();
    run_ticks(3);
    exp_q.push_back(mk(16'h0003, 1'b1, 1'b0, 1'b0));
    check_snap("before_async_rst", cur());
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    exp_q.push_back(mk(16'h0000, 1'b0, 1'b0, 1'b0));
    check_snap("async_rst", cur());
    step();
    rst = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
